quiz_round_ctrl: RTL and testbench
==================================

QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DIGITS, 3, answer digits (BCD, 4 bits each)
- ROUNDS, 8, questions per game
- HP_INIT, 3, lives at game start (1..15)
- TICK_DIV, 50_000_000, CLK cycles per countdown tick
- READY_TICKS, 3, countdown length before first question
- RESULT_CYC, 25_000_000, cycles RESULT is held
- TIMEOUT_TICKS, 10, ticks allowed per question
REQ-002 SHALL have ports (name, direction, width, meaning):
- CLK, in, 1, single clock; all state on rising edge
- RST, in, 1, reset, synchronous, active-low
- START, in, 1, one-cycle pulse; begins game
- DIGIT_VLD, in, 1, one-cycle pulse; DIGIT_IN valid
- DIGIT_IN, in, 4, BCD digit
- CLR, in, 1, pulse; clear entry
- DEC, in, 1, pulse; submit entry
- Q_REQ, out, 1, one-cycle pulse; request question Q_IDX
- Q_IDX, out, $clog2(ROUNDS), current round index
- Q_VLD, in, 1, Q_ANS valid (any cycle at/after Q_REQ)
- Q_ANS, in, 4*DIGITS, expected answer, BCD, digit 0 in LSBs
- ENTRY, out, 4*DIGITS, entered digits, newest in LSBs
- STATE, out, 3, FSM state code
- HP, out, 4, remaining lives
- SCORE, out, 4, correct answers, saturating at 15
- COUNT, out, 4, countdown ticks remaining (READY/ANSWER)
- LED, out, 1, high in RESULT when last answer correct
- DONE, out, 1, high in OVER

Function
REQ-003 SHALL implement states IDLE=0, READY=1, FETCH=2, ANSWER=3, JUDGE=4, RESULT=5, OVER=6.
REQ-004 IDLE: START -> READY; HP<=HP_INIT, SCORE<=0, Q_IDX<=0, COUNT<=READY_TICKS.
REQ-005 READY: COUNT decrements each TICK_DIV cycles; at tick with COUNT==1 -> FETCH.
REQ-006 FETCH: Q_REQ pulsed exactly one cycle on entry; wait for Q_VLD; latch Q_ANS; clear ENTRY; COUNT<=TIMEOUT_TICKS; -> ANSWER.
REQ-007 ANSWER: DIGIT_VLD with DIGIT_IN<=9 shifts ENTRY left 4 bits, inserts digit at LSBs; oldest digit lost past DIGITS; DIGIT_IN>9 ignored.
REQ-008 CLR clears ENTRY and digit count; CLR with DIGIT_VLD same cycle: CLR wins.
REQ-009 DEC with zero digits entered SHALL be ignored; otherwise -> JUDGE; DEC wins over same-cycle DIGIT_VLD/CLR.
REQ-010 JUDGE (one cycle): ENTRY==latched answer -> SCORE+1 (sat.), LED flag set; else HP-1 (floor 0), flag clear; -> RESULT.
REQ-011 RESULT held RESULT_CYC cycles; then -> OVER if HP==0 or Q_IDX==ROUNDS-1, else Q_IDX+1 -> FETCH.
REQ-012 OVER: DONE=1; START -> READY with REQ-004 re-initialisation.
REQ-013 Tick prescaler SHALL restart at 0 on every entry to READY/ANSWER.
REQ-014 START outside IDLE/OVER SHALL be ignored; DIGIT_VLD/CLR/DEC outside ANSWER ignored.

Reset
REQ-015 RST low at a rising edge SHALL force IDLE from any state, incl. mid-FETCH/RESULT.
REQ-016 Reset values: STATE=0, ENTRY=0, HP=HP_INIT, SCORE=0, COUNT=0, Q_IDX=0, Q_REQ=0, LED=0, DONE=0.

Configuration
REQ-017 Macro QUIZ_TIMEOUT_EN defined: ANSWER COUNT decrements per tick; tick at COUNT==1 -> JUDGE, judged wrong regardless of ENTRY.
REQ-018 Macro undefined: no timeout logic; COUNT=0 in ANSWER; ANSWER leaves only via DEC.

Structure
REQ-019 Package quiz_pkg SHALL hold state enum/codes and BCD digit width constant.
REQ-020 Sub-module quiz_tick_div (prescaler, sync clear, one-cycle TICK out) SHALL be instantiated once.

Verification (TICK_DIV=4, RESULT_CYC=3, ROUNDS=2, HP_INIT=2)
REQ-021 START; answer 0x123 vs Q_ANS 0x123 both rounds -> SCORE=2, HP=2, LED=1 in each RESULT, DONE=1.
REQ-022 Two wrong answers in round 0/1 -> HP 2->1->0, SCORE=0, OVER after round 1.
REQ-023 Digits 1,2,3,4 then DEC -> ENTRY=0x234; CLR+DIGIT_VLD(7) same cycle -> ENTRY=0.
REQ-024 DEC with empty ENTRY -> stays ANSWER; DIGIT_IN=0xA -> ENTRY unchanged.
REQ-025 RST low in RESULT -> next cycle STATE=0, all REQ-016 values.
REQ-026 QUIZ_TIMEOUT_EN, TIMEOUT_TICKS=2: no input -> JUDGE after 8 cycles, HP decremented; Q_REQ exactly one pulse per round.

Source files
------------

// File: rtl/quiz_pkg.sv
// Shared state codes and BCD constants for the quiz round controller.
package quiz_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_FETCH  = 3'd2,
    S_ANSWER = 3'd3,
    S_JUDGE  = 3'd4,
    S_RESULT = 3'd5,
    S_OVER   = 3'd6
  } state_e;

  function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/quiz_tick_div.sv
// Countdown prescaler: one-cycle o_tick every DIV cycles, restarted by i_clr.
module quiz_tick_div #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= W'(DIV - 1);
    end else if (r_cnt == '0) begin
      r_cnt <= W'(DIV - 1);
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: countdown, question fetch, BCD entry, judging, scoring.
// Define QUIZ_TIMEOUT_EN to give each question a TIMEOUT_TICKS answer window.
//
// state  | meaning
// IDLE   | waiting for START
// READY  | pre-game countdown
// FETCH  | question requested, waiting for Q_VLD
// ANSWER | collecting digits until DEC (or timeout)
// JUDGE  | compare entry with answer, update score/lives
// RESULT | show outcome for RESULT_CYC cycles
// OVER   | game finished, START restarts
module quiz_round_ctrl #(
  parameter int DIGITS        = 3,
  parameter int ROUNDS        = 8,
  parameter int HP_INIT       = 3,
  parameter int TICK_DIV      = 50_000_000,
  parameter int READY_TICKS   = 3,
  parameter int RESULT_CYC    = 25_000_000,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        DIGIT_VLD,
  input  logic [3:0]                  DIGIT_IN,
  input  logic                        CLR,
  input  logic                        DEC,
  output logic                        Q_REQ,
  output logic [$clog2(ROUNDS)-1:0]   Q_IDX,
  input  logic                        Q_VLD,
  input  logic [4*DIGITS-1:0]         Q_ANS,
  output logic [4*DIGITS-1:0]         ENTRY,
  output logic [2:0]                  STATE,
  output logic [3:0]                  HP,
  output logic [3:0]                  SCORE,
  output logic [3:0]                  COUNT,
  output logic                        LED,
  output logic                        DONE
);

  import quiz_pkg::*;

  localparam int EW = DIGITS * BCD_W;
  localparam int QW = $clog2(ROUNDS);
  localparam int RW = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;

`ifdef QUIZ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [3:0] TO_LOAD = TIMEOUT_EN ? 4'(TIMEOUT_TICKS) : 4'd0;

  state_e          r_state;
  state_e          w_next;
  logic [EW-1:0]   r_entry;
  logic [EW-1:0]   r_ans;
  logic            r_any_dig;
  logic [3:0]      r_hp;
  logic [3:0]      r_score;
  logic [3:0]      r_count;
  logic [QW-1:0]   r_qidx;
  logic            r_qreq;
  logic            r_led;
  logic            r_timeout;
  logic [RW-1:0]   r_res_cnt;

  logic            w_tick;
  logic            w_tick_clr;
  logic            w_ans_tick;
  logic            w_timeout;
  logic            w_dec_ok;
  logic            w_judge_ok;
  logic            w_res_done;

  // Held in clear outside the counting states, so each READY/ANSWER visit starts fresh.
  assign w_tick_clr = (r_state != S_READY) && (r_state != S_ANSWER);

  quiz_tick_div #(.DIV(TICK_DIV)) u_tick_div (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick)
  );

`ifdef QUIZ_TIMEOUT_EN
  assign w_ans_tick = w_tick;
`else
  assign w_ans_tick = 1'b0;
`endif

  assign w_timeout  = (r_state == S_ANSWER) && w_ans_tick && (r_count == 4'd1);
  assign w_dec_ok   = DEC && r_any_dig;
  assign w_judge_ok = !r_timeout && (r_entry == r_ans);
  assign w_res_done = (r_res_cnt == '0);

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_OVER: if (START) w_next = S_READY;
      S_READY:        if (w_tick && r_count == 4'd1) w_next = S_FETCH;
      S_FETCH:        if (Q_VLD) w_next = S_ANSWER;
      S_ANSWER:       if (w_dec_ok || w_timeout) w_next = S_JUDGE;
      S_JUDGE:        w_next = S_RESULT;
      S_RESULT: begin
        if (w_res_done)
          w_next = (r_hp == 4'd0 || r_qidx == QW'(ROUNDS - 1)) ? S_OVER : S_FETCH;
      end
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    STATE = r_state;
    DONE  = (r_state == S_OVER);
    LED   = (r_state == S_RESULT) && r_led;
    Q_REQ = r_qreq;
    Q_IDX = r_qidx;
    ENTRY = r_entry;
    HP    = r_hp;
    SCORE = r_score;
    COUNT = r_count;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_entry   <= '0;
      r_ans     <= '0;
      r_any_dig <= 1'b0;
      r_hp      <= 4'(HP_INIT);
      r_score   <= '0;
      r_count   <= '0;
      r_qidx    <= '0;
      r_qreq    <= 1'b0;
      r_led     <= 1'b0;
      r_timeout <= 1'b0;
      r_res_cnt <= '0;
    end else begin
      r_qreq <= (w_next == S_FETCH) && (r_state != S_FETCH);
      case (r_state)
        S_IDLE, S_OVER: begin
          if (START) begin
            r_hp    <= 4'(HP_INIT);
            r_score <= '0;
            r_qidx  <= '0;
            r_count <= 4'(READY_TICKS);
          end
        end
        S_READY: if (w_tick) r_count <= r_count - 1'b1;
        S_FETCH: begin
          if (Q_VLD) begin
            r_ans     <= Q_ANS;
            r_entry   <= '0;
            r_any_dig <= 1'b0;
            r_count   <= TO_LOAD;
          end
        end
        S_ANSWER: begin
          if (w_dec_ok) begin
            r_timeout <= 1'b0;
          end else begin
            if (CLR) begin
              r_entry   <= '0;
              r_any_dig <= 1'b0;
            end else if (DIGIT_VLD && bcd_ok(DIGIT_IN)) begin
              r_entry   <= (r_entry << BCD_W) | EW'(DIGIT_IN);
              r_any_dig <= 1'b1;
            end
            if (w_ans_tick) begin
              r_count <= r_count - 1'b1;
              if (r_count == 4'd1) r_timeout <= 1'b1;
            end
          end
        end
        S_JUDGE: begin
          if (w_judge_ok) begin
            if (r_score != 4'd15) r_score <= r_score + 1'b1;
            r_led <= 1'b1;
          end else begin
            if (r_hp != 4'd0) r_hp <= r_hp - 1'b1;
            r_led <= 1'b0;
          end
          r_res_cnt <= RW'(RESULT_CYC - 1);
        end
        S_RESULT: begin
          if (!w_res_done)               r_res_cnt <= r_res_cnt - 1'b1;
          else if (w_next == S_FETCH)    r_qidx    <= r_qidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed games, entry vector table, randomized run vs reference model.
module tb_quiz_round_ctrl;

  localparam int DIGITS        = 3;
  localparam int ROUNDS        = 2;
  localparam int HP_INIT       = 2;
  localparam int TICK_DIV      = 4;
  localparam int READY_TICKS   = 3;
  localparam int RESULT_CYC    = 3;
  localparam int TIMEOUT_TICKS = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0, DIGIT_VLD = 1'b0, CLR = 1'b0, DEC = 1'b0, Q_VLD = 1'b0;
  logic [3:0]  DIGIT_IN = '0;
  logic [11:0] Q_ANS = '0;
  logic        Q_REQ, LED, DONE;
  logic [0:0]  Q_IDX;
  logic [11:0] ENTRY;
  logic [2:0]  STATE;
  logic [3:0]  HP, SCORE, COUNT;

  int n_checks = 0;
  int n_errors = 0;
  int n_qreq   = 0;

  quiz_round_ctrl #(
    .DIGITS(DIGITS), .ROUNDS(ROUNDS), .HP_INIT(HP_INIT), .TICK_DIV(TICK_DIV),
    .READY_TICKS(READY_TICKS), .RESULT_CYC(RESULT_CYC), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIGIT_VLD(DIGIT_VLD), .DIGIT_IN(DIGIT_IN),
    .CLR(CLR), .DEC(DEC), .Q_REQ(Q_REQ), .Q_IDX(Q_IDX), .Q_VLD(Q_VLD), .Q_ANS(Q_ANS),
    .ENTRY(ENTRY), .STATE(STATE), .HP(HP), .SCORE(SCORE), .COUNT(COUNT), .LED(LED), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (Q_REQ === 1'b1) n_qreq++;

  // Reference model: state codes as plain ints, entry as a digit queue, ticks from elapsed-cycle arithmetic.
  int m_state = 0, m_hp = HP_INIT, m_score = 0, m_qidx = 0, m_count = 0, m_el = 0, m_ans = 0;
  bit m_led = 0, m_qreq = 0, m_to = 0;
  int m_dig[$];

  function automatic int entry_val();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return v;
  endfunction

  always @(posedge CLK) begin
    int  nxt;
    bit  tick;
    bit  ok;
    nxt  = m_state;
    tick = (m_el % TICK_DIV) == TICK_DIV - 1;
    if (!RST) begin
      m_state = 0; m_dig.delete(); m_hp = HP_INIT; m_score = 0; m_count = 0;
      m_qidx = 0; m_qreq = 0; m_led = 0; m_to = 0; m_ans = 0; m_el = 0;
    end else begin
      case (m_state)
        0, 6: if (START) begin
          nxt = 1; m_hp = HP_INIT; m_score = 0; m_qidx = 0; m_count = READY_TICKS;
        end
        1: if (tick) begin
          if (m_count == 1) nxt = 2;
          m_count--;
        end
        2: if (Q_VLD) begin
          m_ans = int'(Q_ANS); m_dig.delete(); nxt = 3;
`ifdef QUIZ_TIMEOUT_EN
          m_count = TIMEOUT_TICKS;
`else
          m_count = 0;
`endif
        end
        3: if (DEC && m_dig.size() > 0) begin
          nxt = 4; m_to = 0;
        end else begin
          if (CLR) m_dig.delete();
          else if (DIGIT_VLD && DIGIT_IN <= 9) begin
            m_dig.push_back(int'(DIGIT_IN));
            if (m_dig.size() > DIGITS) void'(m_dig.pop_front());
          end
`ifdef QUIZ_TIMEOUT_EN
          if (tick) begin
            if (m_count == 1) begin nxt = 4; m_to = 1; end
            m_count--;
          end
`endif
        end
        4: begin
          ok = !m_to && entry_val() == m_ans;
          if (ok) begin m_score = (m_score < 15) ? m_score + 1 : 15; m_led = 1; end
          else    begin m_hp = (m_hp > 0) ? m_hp - 1 : 0; m_led = 0; end
          nxt = 5;
        end
        5: if (m_el == RESULT_CYC - 1) begin
          if (m_hp == 0 || m_qidx == ROUNDS - 1) nxt = 6;
          else begin m_qidx++; nxt = 2; end
        end
        default: nxt = 0;
      endcase
      m_qreq  = (nxt == 2) && (m_state != 2);
      m_el    = (nxt != m_state) ? 0 : m_el + 1;
      m_state = nxt;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic st, input logic dv, input logic [3:0] d,
                     input logic cl, input logic de);
    START = st; DIGIT_VLD = dv; DIGIT_IN = d; CLR = cl; DEC = de;
    @(posedge CLK); #1;
    START = 0; DIGIT_VLD = 0; CLR = 0; DEC = 0;
  endtask

  task automatic cyc_idle();
    cyc(0, 0, 4'd0, 0, 0);
  endtask

  task automatic wait_state(input int s, input int maxc, output int n);
    n = 0;
    while (int'(STATE) != s && n < maxc) begin cyc_idle(); n++; end
    chk($sformatf("wait_state_%0d", s), int'(STATE), s);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, STATE, 0);
    chk({tag, "_entry"}, ENTRY, 0);
    chk({tag, "_hp"},    HP,    HP_INIT);
    chk({tag, "_score"}, SCORE, 0);
    chk({tag, "_count"}, COUNT, 0);
    chk({tag, "_qidx"},  Q_IDX, 0);
    chk({tag, "_qreq"},  Q_REQ, 0);
    chk({tag, "_led"},   LED,   0);
    chk({tag, "_done"},  DONE,  0);
  endtask

  typedef struct {
    logic       dv;
    logic [3:0] din;
    logic       clr;
    logic       dec;
    int         exp_state;
    int         exp_entry;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, q0;
    logic [31:0] act_b, exp_b;
    int ans_set[3];

    vecs[0] = '{1, 4'd5,  0, 0, 3, 'h005};
    vecs[1] = '{1, 4'd7,  1, 0, 3, 'h000};
    vecs[2] = '{1, 4'd1,  0, 0, 3, 'h001};
    vecs[3] = '{1, 4'd2,  0, 0, 3, 'h012};
    vecs[4] = '{1, 4'hA,  0, 0, 3, 'h012};
    vecs[5] = '{1, 4'd3,  0, 0, 3, 'h123};
    vecs[6] = '{1, 4'd4,  0, 0, 3, 'h234};
    vecs[7] = '{0, 4'd0,  0, 1, 4, 'h234};

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_vals("reset");
    RST = 1;

    // Game 1: both rounds answered correctly
    Q_VLD = 1; Q_ANS = 12'h123;
    cyc(1, 0, 0, 0, 0);
    chk("g1_state_ready", STATE, 1);
    chk("g1_count_ready", COUNT, READY_TICKS);
    cyc(1, 0, 0, 0, 0);
    wait_state(2, 40, n);
    chk("g1_ready_len", n + 1, READY_TICKS * TICK_DIV);
    chk("g1_qreq_r0", Q_REQ, 1);
    cyc_idle();
    chk("g1_answer", STATE, 3);
    chk("g1_qreq_low", Q_REQ, 0);
    cyc(0, 1, 4'd1, 0, 0); cyc(0, 1, 4'd2, 0, 0); cyc(0, 1, 4'd3, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("g1_judge", STATE, 4);
    cyc_idle();
    chk("g1_r0_led", LED, 1);
    chk("g1_r0_score", SCORE, 1);
    wait_state(2, 10, n);
    chk("g1_result_len", n, RESULT_CYC);
    chk("g1_qidx1", Q_IDX, 1);
    cyc_idle();
    cyc(0, 1, 4'd1, 0, 0); cyc(0, 1, 4'd2, 0, 0); cyc(0, 1, 4'd3, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc_idle();
    chk("g1_r1_led", LED, 1);
    wait_state(6, 10, n);
    chk("g1_score", SCORE, 2);
    chk("g1_hp", HP, 2);
    chk("g1_done", DONE, 1);
    chk("g1_led_over", LED, 0);

    // Game 2: two wrong answers, delayed Q_VLD, empty DEC ignored
    Q_VLD = 0; Q_ANS = 12'h555;
    q0 = n_qreq;
    cyc(1, 0, 0, 0, 0);
    chk("g2_restart", STATE, 1);
    chk("g2_done_low", DONE, 0);
    chk("g2_score_clr", SCORE, 0);
    chk("g2_qidx_clr", Q_IDX, 0);
    wait_state(2, 40, n);
    repeat (3) cyc_idle();
    chk("g2_fetch_wait", STATE, 2);
    chk("g2_qreq_once", Q_REQ, 0);
    Q_VLD = 1;
    cyc_idle();
    chk("g2_answer", STATE, 3);
    chk("g2_qreq_count", n_qreq - q0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("g2_dec_empty", STATE, 3);
    cyc(0, 1, 4'd1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc_idle();
    chk("g2_r0_hp", HP, 1);
    chk("g2_r0_led", LED, 0);
    wait_state(2, 10, n);
    cyc_idle();
    cyc(0, 1, 4'd9, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc_idle();
    chk("g2_r1_hp", HP, 0);
    wait_state(6, 10, n);
    chk("g2_score", SCORE, 0);
    chk("g2_done", DONE, 1);

    // Game 3: entry vector table, then reset during RESULT
    Q_ANS = 12'h999;
    cyc(1, 0, 0, 0, 0);
    wait_state(2, 40, n);
    cyc_idle();
    for (int i = 0; i < 8; i++) begin
      cyc(0, vecs[i].dv, vecs[i].din, vecs[i].clr, vecs[i].dec);
      chk($sformatf("vec%0d_state", i), STATE, vecs[i].exp_state);
      chk($sformatf("vec%0d_entry", i), ENTRY, vecs[i].exp_entry);
    end
    cyc_idle();
    chk("g3_result", STATE, 5);
    chk("g3_hp", HP, 1);
    RST = 0;
    cyc_idle();
    chk_reset_vals("rst_result");
    RST = 1;

`ifdef QUIZ_TIMEOUT_EN
    q0 = n_qreq;
    cyc(1, 0, 0, 0, 0);
    wait_state(2, 40, n);
    cyc_idle();
    chk("to_count_load", COUNT, TIMEOUT_TICKS);
    wait_state(4, 20, n);
    chk("to_r0_len", n, TIMEOUT_TICKS * TICK_DIV);
    cyc_idle();
    chk("to_r0_hp", HP, 1);
    wait_state(2, 10, n);
    cyc_idle();
    wait_state(4, 20, n);
    chk("to_r1_len", n, TIMEOUT_TICKS * TICK_DIV);
    cyc_idle();
    chk("to_r1_hp", HP, 0);
    wait_state(6, 10, n);
    chk("to_qreq_pulses", n_qreq - q0, 2);
`else
    cyc(1, 0, 0, 0, 0);
    wait_state(2, 40, n);
    cyc_idle();
    chk("nto_count", COUNT, 0);
    repeat (40) cyc_idle();
    chk("nto_hold", STATE, 3);
    cyc(0, 1, 4'd1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("nto_dec", STATE, 4);
`endif

    // Randomized run against the reference model
    ans_set = '{'h123, 'h012, 'h321};
    for (int i = 0; i < 3000; i++) begin
      RST       = ($urandom_range(0, 299) != 0);
      START     = ($urandom_range(0, 9) == 0);
      DIGIT_VLD = ($urandom_range(0, 9) < 4);
      DIGIT_IN  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 3));
      CLR       = ($urandom_range(0, 19) == 0);
      DEC       = ($urandom_range(0, 7) == 0);
      Q_VLD     = ($urandom_range(0, 2) == 0);
      Q_ANS     = 12'(ans_set[$urandom_range(0, 2)]);
      @(posedge CLK); #1;
      act_b = {STATE, ENTRY, HP, SCORE, COUNT, LED, DONE, Q_REQ, Q_IDX};
      exp_b = {3'(m_state), 12'(entry_val()), 4'(m_hp), 4'(m_score), 4'(m_count),
               (m_state == 5) && m_led, m_state == 6, m_qreq, 1'(m_qidx)};
      chk($sformatf("rand_cyc%0d", i), int'(act_b), int'(exp_b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
